// File: rtl/uart_frame_transmitter.sv
// UART transmitter: valid/ready input FIFO feeding a start/data/parity/stop serialiser.
// Bit period, parity and stop count are latched per frame when the word is popped.
module uart_frame_transmitter #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          UART_clk,
  input  logic                          reset,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          stop_bits,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  output logic                          serial_data_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                     r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr, r_rd_ptr;
  logic [AW:0]                r_count;
  logic [DATA_WIDTH-1:0]      r_shift, w_shift_nxt;
  logic [PRESCALE_WIDTH-1:0]  r_period, r_pcnt;
  logic [BW-1:0]              r_bit;
  logic                       r_pen, r_stop2, r_parbit, r_tx;
  logic                       w_write, w_pop, w_tick, w_last_data, w_last_stop;
  logic                       w_fifo_empty, w_line_nxt;

  assign w_fifo_empty = (r_count == '0);
  assign data_ready   = (r_count != CNT_FULL);
  assign w_write      = data_valid & data_ready;
  assign w_tick       = (r_pcnt == r_period - PRESCALE_WIDTH'(1));
  assign w_last_data  = (r_bit == BW'(DATA_WIDTH-1));
  assign w_last_stop  = (r_bit == {{(BW-1){1'b0}}, r_stop2});

  assign serial_data_out = r_tx;
  assign busy            = (r_state != S_IDLE);
  assign fifo_count      = r_count;

  always_ff @(posedge UART_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!w_fifo_empty) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick && w_last_data) w_state_nxt = r_pen ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_tick && w_last_stop) w_state_nxt = w_fifo_empty ? S_IDLE : S_START;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Line value is computed for the next state so the registered output
  // changes on the same edge as the state.
  always_comb begin
    w_pop       = (w_state_nxt == S_START) && (r_state == S_IDLE || r_state == S_STOP);
    w_shift_nxt = r_shift;
    if (w_pop)                          w_shift_nxt = r_mem[r_rd_ptr];
    else if (r_state == S_DATA && w_tick) w_shift_nxt = r_shift >> 1;
    w_line_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_line_nxt = 1'b0;
      S_DATA:   w_line_nxt = w_shift_nxt[0];
      S_PARITY: w_line_nxt = r_parbit;
      default:  w_line_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge UART_clk or posedge reset) begin
    if (reset) begin
      r_tx     <= 1'b1;
      r_shift  <= '0;
      r_period <= PRESCALE_WIDTH'(1);
      r_pcnt   <= '0;
      r_bit    <= '0;
      r_pen    <= 1'b0;
      r_stop2  <= 1'b0;
      r_parbit <= 1'b0;
    end else begin
      r_tx    <= w_line_nxt;
      r_shift <= w_shift_nxt;
      if (w_pop) begin
        r_period <= (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
        r_pen    <= parity_enable;
        r_stop2  <= stop_bits;
        r_parbit <= (^r_mem[r_rd_ptr]) ^ parity_type;
      end
      if (w_state_nxt != r_state || w_tick || r_state == S_IDLE) r_pcnt <= '0;
      else                                                       r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
      if (w_state_nxt != r_state) r_bit <= '0;
      else if (w_tick)            r_bit <= r_bit + BW'(1);
    end
  end

  always_ff @(posedge UART_clk) begin
    if (w_write) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge UART_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Directed bench: table of single-frame vectors plus FIFO, config-change and reset sequences.
module tb_uart_frame_transmitter;
  logic       UART_clk = 1'b0;
  logic       reset;
  logic [5:0] prescale;
  logic       parity_enable, parity_type, stop_bits;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready, serial_data_out, busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  uart_frame_transmitter #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6), .FIFO_DEPTH(4)) dut (
    .UART_clk(UART_clk), .reset(reset), .prescale(prescale),
    .parity_enable(parity_enable), .parity_type(parity_type), .stop_bits(stop_bits),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .serial_data_out(serial_data_out), .busy(busy), .fifo_count(fifo_count)
  );

  always #5 UART_clk = ~UART_clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // seq holds the frame in time order, first bit at position nbits-1
  typedef struct {
    logic [5:0]  prescale;
    logic        pen, ptype, stop2;
    logic [7:0]  data;
    int          period;
    int          nbits;
    logic [11:0] seq;
  } vec_t;

  vec_t vec [5];
  logic cap [0:199];

  initial begin
    int lerr, berr, len, g;
    logic [7:0] word;

    vec[0] = '{6'd8, 1'b1, 1'b0, 1'b0, 8'hA5, 8, 11, 12'b001010010101};
    vec[1] = '{6'd4, 1'b1, 1'b1, 1'b1, 8'hFF, 4, 12, 12'b011111111111};
    vec[2] = '{6'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1, 10, 12'b000000000001};
    vec[3] = '{6'd0, 1'b1, 1'b0, 1'b0, 8'h01, 1, 11, 12'b001000000011};
    vec[4] = '{6'd3, 1'b1, 1'b1, 1'b1, 8'h3C, 3, 12, 12'b000111100111};

    reset = 1'b1; prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
    stop_bits = 1'b0; data_in = '0; data_valid = 1'b0;
    repeat (2) @(negedge UART_clk);
    chk("rst_line", serial_data_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", data_ready, 1);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;

    // single frames from idle
    for (int v = 0; v < 5; v++) begin
      @(negedge UART_clk);
      prescale = vec[v].prescale; parity_enable = vec[v].pen; parity_type = vec[v].ptype;
      stop_bits = vec[v].stop2; data_in = vec[v].data; data_valid = 1'b1;
      @(posedge UART_clk);
      @(negedge UART_clk);
      data_valid = 1'b0;
      len = vec[v].nbits * vec[v].period;
      lerr = 0; berr = 0;
      for (int k = 0; k < len; k++) begin
        @(negedge UART_clk);
        if (serial_data_out !== vec[v].seq[vec[v].nbits - 1 - k / vec[v].period]) lerr++;
        if (busy !== 1'b1) berr++;
      end
      chk($sformatf("v%0d_line_errs", v), lerr, 0);
      chk($sformatf("v%0d_busy_errs", v), berr, 0);
      @(negedge UART_clk);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_idle_line", v), serial_data_out, 1);
    end

    // FIFO fill, backpressure, back-to-back frames
    prescale = 6'd2; parity_enable = 1'b0; stop_bits = 1'b0;
    data_in = 8'd1; data_valid = 1'b1;
    berr = 0;
    @(posedge UART_clk);
    fork
      begin
        @(posedge UART_clk);
        for (int c = 0; c < 120; c++) begin
          @(negedge UART_clk);
          cap[c] = serial_data_out;
          if (busy !== 1'b1) berr++;
        end
      end
      begin
        for (int w = 2; w <= 6; w++) begin
          @(negedge UART_clk);
          data_in = 8'(w);
          if (w == 3) begin
            chk("pop_at_once_count", fifo_count, 1);
            chk("pop_at_once_busy", busy, 1);
          end
          if (w == 6) begin
            chk("full_count", fifo_count, 4);
            chk("full_ready", data_ready, 0);
            g = 0;
            while (!data_ready && g < 100) begin
              @(negedge UART_clk);
              g++;
            end
            chk("refill_ready", data_ready, 1);
            chk("refill_count", fifo_count, 3);
          end
          @(posedge UART_clk);
        end
        @(negedge UART_clk);
        data_valid = 1'b0;
        chk("w6_count", fifo_count, 4);
      end
    join
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < 8; b++) word[b] = cap[f*20 + (b+1)*2];
      chk($sformatf("b2b_f%0d_start", f), cap[f*20], 0);
      chk($sformatf("b2b_f%0d_word", f), word, f + 1);
      chk($sformatf("b2b_f%0d_stop", f), cap[f*20 + 18], 1);
    end
    chk("b2b_busy_gaps", berr, 0);
    @(negedge UART_clk);
    chk("b2b_end_busy", busy, 0);

    // prescale change mid-frame only affects the next frame
    prescale = 6'd8; data_in = 8'h00; data_valid = 1'b1;
    @(posedge UART_clk);
    @(negedge UART_clk);
    data_in = 8'hFF;
    @(posedge UART_clk);
    lerr = 0; berr = 0;
    for (int c = 0; c < 110; c++) begin
      @(negedge UART_clk);
      if (c == 0) data_valid = 1'b0;
      if (c == 20) prescale = 6'd3;
      if (serial_data_out !== ((c < 72) ? 1'b0 : (c < 80) ? 1'b1 : (c < 83) ? 1'b0 : 1'b1)) lerr++;
      if (busy !== 1'b1) berr++;
    end
    chk("cfg_line_errs", lerr, 0);
    chk("cfg_busy_errs", berr, 0);
    @(negedge UART_clk);
    chk("cfg_end_busy", busy, 0);

    // reset during DATA with two words queued
    prescale = 6'd8; data_in = 8'h11; data_valid = 1'b1;
    @(posedge UART_clk);
    @(negedge UART_clk); data_in = 8'h22;
    @(posedge UART_clk);
    @(negedge UART_clk); data_in = 8'h33;
    @(posedge UART_clk);
    @(negedge UART_clk); data_valid = 1'b0;
    chk("rstmid_queued", fifo_count, 2);
    repeat (16) @(negedge UART_clk);
    reset = 1'b1;
    #1;
    chk("rstmid_line", serial_data_out, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_count", fifo_count, 0);
    chk("rstmid_ready", data_ready, 1);
    @(negedge UART_clk);
    reset = 1'b0;
    lerr = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge UART_clk);
      if (serial_data_out !== 1'b1 || busy !== 1'b0) lerr++;
    end
    chk("rstmid_quiet", lerr, 0);
    data_in = 8'h5A; data_valid = 1'b1;
    @(posedge UART_clk);
    @(negedge UART_clk); data_valid = 1'b0;
    @(negedge UART_clk);
    chk("rstmid_new_start", serial_data_out, 0);
    chk("rstmid_new_busy", busy, 1);
    g = 0;
    while (busy && g < 200) begin
      @(negedge UART_clk);
      g++;
    end
    chk("rstmid_new_done", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_transmitter.md
# uart_frame_transmitter

Parametrised UART transmitter for the UART clock domain, the next generation of the fixed 8-bit, prescale-8, 11-bit-frame transmitter used in the current system. It takes parallel words through a valid/ready handshake and buffers them in an internal FIFO. It serialises each word as start bit, LSB-first data, optional parity and one or two stop bits, with a runtime-programmable bit period. A `busy` flag is exported for the system controller and for bench synchronisation.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame (5..9 supported).
- `PRESCALE_WIDTH`, 6: width of the `prescale` input.
- `FIFO_DEPTH`, 4: input FIFO entries (power of two, ≥2).
- `UART_clk` input 1: sole clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `prescale` input PRESCALE_WIDTH: `UART_clk` cycles per bit; 0 treated as 1.
- `parity_enable` input 1: 1 inserts a parity bit after the data bits.
- `parity_type` input 1: 0 even, 1 odd.
- `stop_bits` input 1: 0 one stop bit, 1 two stop bits.
- `data_in` input DATA_WIDTH: word to transmit.
- `data_valid` input 1: `data_in` offered this cycle.
- `data_ready` output 1: FIFO not full; a write occurs when `data_valid & data_ready`.
- `serial_data_out` output 1: serial line, registered, idle high.
- `busy` output 1: a frame is on the line.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: words waiting in the FIFO, excluding the word being shifted.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: line high, `busy` 0. When the FIFO is non-empty, pop the head into the shift register and latch `prescale`, `parity_enable`, `parity_type` and `stop_bits`. Then go to START.
- START: drive 0 for one bit period, then go to DATA.
- DATA: drive shift[0] and shift right each bit period, for DATA_WIDTH periods. Then go to PARITY if parity is enabled, else STOP.
- PARITY: drive the XOR of the data bits for even parity, or its inverse for odd parity, for one bit period.
- STOP: drive 1 for one bit period, or two when `stop_bits` = 1.
- End of the last stop period:
  - If the FIFO is non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
  - Otherwise: go to IDLE.
- Configuration inputs are sampled only at frame start. Changes mid-frame affect the next frame only.
- FIFO write and pop in the same cycle: both occur and `fifo_count` is unchanged.
- When full, `data_ready` is 0 and `data_valid` is ignored. `data_ready` rises the cycle after a pop.
- Reset values: `serial_data_out` 1, `busy` 0, `data_ready` 1, `fifo_count` 0, FSM IDLE.
- A reset mid-frame aborts the frame immediately: the line returns high asynchronously and the FIFO contents are discarded.

## Timing
- Bit period P = max(prescale,1) cycles.
- Frame length = (1 + DATA_WIDTH + parity_enable + 1 + stop_bits) × P cycles.
- Start latency from idle:
  - Word written at edge E.
  - Pop and START entry at edge E+1.
  - `serial_data_out` = 0 and `busy` = 1 from edge E+1.
- `busy` stays 1 through the final stop cycle. It falls at the edge after the last stop period unless a back-to-back frame starts, in which case it stays 1.
- Bit counter and prescale counter both reset at each bit boundary. The prescale counter counts 0..P−1, and the state advances when it reaches P−1.
- `fifo_count` and `data_ready` update on the edge following the write or pop.

## Test plan
- Default frame:
  - Stimulus: prescale=8, parity even, 1 stop, write 0xA5 while idle.
  - Response: line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; `busy` high for exactly 88 cycles; line high afterwards.
- Odd parity, two stops:
  - Stimulus: prescale=4, parity odd, 2 stops, write 0xFF.
  - Response: 0, eight 1s, parity 1, 1, 1; 12 bits = 48 cycles; `busy` 48 cycles.
- Parity off:
  - Stimulus: prescale=1, parity off, write 0x00.
  - Response: 10 bits, 10 cycles: 0×9 then 1.
- FIFO fill and back-to-back:
  - Stimulus: prescale=2; hold `data_valid` with words 1..6 on consecutive cycles.
  - Response:
    - Word 1 popped at once.
    - `data_ready` drops after the FIFO holds 4 words (words 2..5); `fifo_count` = 4.
    - Word 6 is accepted only after the next pop.
    - All frames are contiguous, with `busy` never falling between them.
- Mid-frame config change:
  - Stimulus: change `prescale` from 8 to 3 during the DATA state.
  - Response: the current frame keeps 8-cycle bits; the next frame uses 3-cycle bits.
- Reset mid-frame:
  - Stimulus: assert `reset` during DATA with 2 words queued.
  - Response: line 1 and `busy` 0 immediately (asynchronous); `fifo_count` 0.
  - After release: nothing is transmitted until a new write.
